bcd_display_scanner: RTL and testbench

Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display. It sits directly upstream of `bcd_to_7segment`. It accepts a packed multi-digit BCD value, double-buffers it, and steps through the digits at a programmable refresh rate. On each step it presents one BCD nibble to the decoder and drives the matching active-low digit enable. New values take effect only at frame boundaries, so a digit never shows a mix of old and new values within a frame.

---
 rtl/bcd_display_scanner.sv | 134 +++++++++++++
 tb/tb_bcd_display_scanner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_scanner
//  Description : Time-multiplexed, double-buffered scan driver for a DIGITS-wide
//                common-anode 7-segment display; feeds bcd_to_7segment.
//                Optional leading-zero blanking when BCD_SCAN_LZB_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame_start
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] C_PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] C_IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]          r_pre;
    logic [IW-1:0]          r_idx;
    logic [4*DIGITS-1:0]    r_shadow;
    logic [4*DIGITS-1:0]    r_active;

    logic                   w_tick;
    logic                   w_wrap;
    logic [IW-1:0]          w_idx_n;
    logic [4*DIGITS-1:0]    w_next_active;
    logic [3:0]             w_nibble;
    logic [DIGITS-1:0]      w_anode_n;
    logic                   w_sel_blank;

    assign w_tick  = (r_pre == C_PRE_LAST);
    assign w_idx_n = (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
    assign w_wrap  = (w_idx_n == '0);

    // A load coinciding with the frame transfer bypasses the shadow register.
    assign w_next_active = w_wrap ? (load ? value_in : r_shadow) : r_active;

    always_comb begin
        w_nibble = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_idx_n == IW'(k)) begin
                w_nibble = w_next_active[4*k +: 4];
            end
        end
    end

    always_comb begin
        w_anode_n = '1;
        for (int k = 0; k < DIGITS; k++) begin
            w_anode_n[k] = (w_idx_n != IW'(k));
        end
    end

`ifdef BCD_SCAN_LZB_EN
    logic [DIGITS:1]        w_zero_run;
    logic [DIGITS-1:0]      w_mask;
    logic [DIGITS-1:0]      w_blank_n;
    logic [DIGITS-1:0]      r_blank;

    // Zero run from the most significant digit downward; digit 0 always shows.
    assign w_zero_run[DIGITS] = 1'b1;
    assign w_mask[0]          = 1'b0;

    genvar gk;
    generate
        for (gk = DIGITS - 1; gk >= 1; gk--) begin : g_zero_run
            assign w_zero_run[gk] = w_zero_run[gk+1] & (w_next_active[4*gk +: 4] == 4'h0);
            assign w_mask[gk]     = w_zero_run[gk];
        end
    endgenerate

    assign w_blank_n = w_wrap ? w_mask : r_blank;

    always_comb begin
        w_sel_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_idx_n == IW'(k)) begin
                w_sel_blank = w_blank_n[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blank <= '0;
        end else if (w_tick && w_wrap) begin
            r_blank <= w_mask;
        end
    end
`else
    assign w_sel_blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre       <= '0;
            r_idx       <= C_IDX_LAST;
            r_shadow    <= '0;
            r_active    <= '0;
            bcd         <= 4'h0;
            anode       <= '1;
            frame_start <= 1'b0;
        end else begin
            r_pre       <= w_tick ? '0 : r_pre + 1'b1;
            frame_start <= 1'b0;
            if (load) begin
                r_shadow <= value_in;
            end
            if (w_tick) begin
                r_idx       <= w_idx_n;
                r_active    <= w_next_active;
                frame_start <= w_wrap;
                if (w_sel_blank) begin
                    anode <= '1;
                    bcd   <= 4'hF;
                end else begin
                    anode <= w_anode_n;
                    bcd   <= w_nibble;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_display_scanner
//  Description : Self-checking bench for bcd_display_scanner (DIGITS=4,
//                REFRESH_DIV=4) against a cycle-count arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

    localparam int DIGITS = 4;
    localparam int RD     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  bcd;
    logic [3:0]  anode;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    // Model: n = rising edges since reset release; digit shown follows from n.
    int          n;
    logic [15:0] m_shadow;
    logic [15:0] m_active;

    bcd_display_scanner #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (RD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value_in    (value_in),
        .bcd         (bcd),
        .anode       (anode),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at n=%0d: got=%0h expected=%0h", tag, n, got, exp);
        end
    endtask

    function automatic int cur_digit();
        return ((n / RD) - 1) % DIGITS;
    endfunction

    task automatic model_reset();
        n        = 0;
        m_shadow = 16'h0;
        m_active = 16'h0;
    endtask

    task automatic model_edge(input logic ld, input logic [15:0] v);
        n++;
        if ((n % RD == 0) && (cur_digit() == 0)) begin
            m_active = ld ? v : m_shadow;
        end
        if (ld) begin
            m_shadow = v;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] exp_an;
        logic [3:0] exp_bcd;
        logic       exp_fs;
        int         d;
        exp_an  = 4'hF;
        exp_bcd = 4'h0;
        exp_fs  = 1'b0;
        if (n >= RD) begin
            d       = cur_digit();
            exp_fs  = (n % RD == 0) && (d == 0);
            exp_an  = 4'hF ^ 4'(1 << d);
            exp_bcd = 4'((m_active >> (4 * d)) & 16'hF);
`ifdef BCD_SCAN_LZB_EN
            if (d != 0 && (m_active >> (4 * d)) == 16'h0) begin
                exp_an  = 4'hF;
                exp_bcd = 4'hF;
            end
`endif
        end
        check_val({tag, "_anode"}, 32'(anode), 32'(exp_an));
        check_val({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
        check_val({tag, "_frame_start"}, 32'(frame_start), 32'(exp_fs));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic ld, input logic [15:0] v, input string tag);
        load     = ld;
        value_in = v;
        @(posedge clk);
        model_edge(ld, v);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] r;
        r = 16'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                r[4*k +: 4] = 4'($urandom_range(0, 15));
            end
        end
        return r;
    endfunction

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        value_in = 16'h0;
        model_reset();
        #3;
        check_outputs("reset");
        @(negedge clk);
        check_outputs("reset_held");
        @(negedge clk);
        reset = 1'b0;

        // Basic load before the first tick, then several frames.
        step(1'b1, 16'h1234, "basic");
        repeat (35) step(1'b0, 16'h0, "basic");

        // Load in the middle of digit 2: current frame keeps the old value.
        while (!(n >= RD && cur_digit() == 2 && (n % RD) == 1)) step(1'b0, 16'h0, "align2");
        step(1'b1, 16'h5678, "dbuf");
        repeat (40) step(1'b0, 16'h0, "dbuf");

        // Load on the very edge that selects digit 0.
        while (((n + 1) % (RD * DIGITS)) != RD) step(1'b0, 16'h0, "align0");
        step(1'b1, 16'h9999, "same_cycle");
        check_val("same_cycle_bcd9", 32'(bcd), 32'h9);
        repeat (20) step(1'b0, 16'h0, "after9");

        // Multiple loads within one frame keep only the last.
        step(1'b1, 16'h1111, "multi");
        step(1'b1, 16'h2222, "multi");
        step(1'b1, 16'h3A4F, "multi");
        repeat (36) step(1'b0, 16'h0, "multi");

        // Asynchronous reset in the middle of digit 1.
        while (!(n >= RD && cur_digit() == 1 && (n % RD) == 2)) step(1'b0, 16'h0, "align1");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(posedge clk);
        #1;
        check_outputs("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        repeat (24) step(1'b0, 16'h0, "post_reset");

        // Leading-zero patterns.
        step(1'b1, 16'h0070, "lz0070");
        repeat (36) step(1'b0, 16'h0, "lz0070");
        step(1'b1, 16'h0000, "lz0000");
        repeat (36) step(1'b0, 16'h0, "lz0000");

        // Randomized loads.
        repeat (400) step(($urandom_range(0, 7) == 0), rand_val(), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
